// File: rtl/rv32m_iterative_mdu.sv
// ---------------------------------------------------------------------------
// rv32m_iterative_mdu
//
// Iterative RV32M multiply/divide unit that sits behind the register file of
// the single-cycle core. One operand bit is processed per clock:
//   - multiply: shift-add into a 64-bit accumulator, sign fixed at the end
//   - divide  : restoring division on magnitudes, signs fixed at the end
// Every operation is accepted in IDLE, runs 32 CALC cycles and reports in
// DONE, so done is high in the 33rd cycle after the accepting edge.
//
// Optional feature (compile-time macro MDU_EARLY_OUT_EN):
//   Divide by zero and DIV/REM signed overflow skip CALC. The special result
//   is registered at the accepting edge and done is high in the very next
//   cycle. Without the macro no bypass logic is built and those cases run
//   through the normal datapath, which produces the same special values.
//
// Ports:
//   clk        in   1      clock, all state on the rising edge
//   rst        in   1      synchronous active-high reset, aborts any op
//   i_start    in   1      request, sampled only in IDLE
//   i_op       in   3      funct3: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//   i_rs1_val  in   XLEN   operand a (src1 register value)
//   i_rs2_val  in   XLEN   operand b (src2 register value)
//   i_rd_in    in   5      destination register index
//   o_busy     out  1      high in CALC and DONE; core stalls
//   o_done     out  1      one-cycle pulse, result/rd_out valid
//   o_result   out  XLEN   register write data, held until next completion
//   o_rd_out   out  5      destination index captured at accept
// ---------------------------------------------------------------------------
module rv32m_iterative_mdu #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_rs1_val,
    input  logic [XLEN-1:0] i_rs2_val,
    input  logic [4:0]      i_rd_in,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result,
    output logic [4:0]      o_rd_out
);

    localparam int DW = 2 * XLEN;

    // FSM encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // funct3 encodings
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    // Two's-complement magnitude when the operand is treated as negative
    function automatic logic [XLEN-1:0] f_mag(input logic [XLEN-1:0] v,
                                              input logic            neg);
        return neg ? (-v) : v;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]      r_op;
    logic [4:0]      r_rd;
    logic            r_neg_res;   // product / quotient must be negated
    logic            r_neg_rem;   // remainder takes the dividend's sign
    logic            r_div_zero;  // divisor was zero: quotient stays all-ones
    // r_a : multiplier (shifts right) / dividend -> quotient (shifts left)
    // r_b : multiplicand / divisor magnitude
    // r_acc: 64-bit product accumulator / partial remainder in low bits
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [DW-1:0]   r_acc;
    logic            r_busy;
    logic            r_done;
    logic [XLEN-1:0] r_result;
    logic [4:0]      r_rd_out;

    // ------------------------------------------------------------------
    // Accept-side decode
    // ------------------------------------------------------------------
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;

    // Operand signedness per funct3 and magnitudes taken at accept
    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        case (i_op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b1;
            end
            OP_MULHSU: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b0;
            end
            OP_MULHU, OP_DIVU, OP_REMU: begin
                w_a_signed = 1'b0;
                w_b_signed = 1'b0;
            end
            default: begin
                w_a_signed = 1'b0;
                w_b_signed = 1'b0;
            end
        endcase
        w_a_neg = w_a_signed & i_rs1_val[XLEN-1];
        w_b_neg = w_b_signed & i_rs2_val[XLEN-1];
        w_a_mag = f_mag(i_rs1_val, w_a_neg);
        w_b_mag = f_mag(i_rs2_val, w_b_neg);
    end

`ifdef MDU_EARLY_OUT_EN
    logic            w_early;
    logic [XLEN-1:0] w_special;
    logic            w_in_div_zero;
    logic            w_in_ovf;

    // Detect divide-by-zero / signed overflow at accept and pick their result
    always_comb begin
        w_in_div_zero = (i_rs2_val == {XLEN{1'b0}});
        // DIV and REM are the signed divides (funct3 bit 0 clear)
        w_in_ovf      = ~i_op[0]
                      & (i_rs1_val == {1'b1, {(XLEN-1){1'b0}}})
                      & (i_rs2_val == {XLEN{1'b1}});
        w_early       = i_op[2] & (w_in_div_zero | w_in_ovf);
        if (w_in_div_zero) begin
            // REM/REMU return the dividend, DIV/DIVU return all-ones
            w_special = i_op[1] ? i_rs1_val : {XLEN{1'b1}};
        end else if (w_in_ovf) begin
            w_special = i_op[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
        end else begin
            w_special = {XLEN{1'b0}};
        end
    end
`endif

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    logic [XLEN:0]   w_mul_sum;
    logic [DW-1:0]   w_mul_nxt;
    logic [XLEN:0]   w_trial;
    logic [XLEN:0]   w_diff;
    logic            w_ge;
    logic [XLEN:0]   w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt;
    logic [DW-1:0]   w_prod;
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;
    logic [XLEN-1:0] w_final;

    // One multiply step, one restoring-divide step, and the final sign fix
    always_comb begin
        // Multiply: add multiplicand into the upper half when the current
        // multiplier bit is set, then shift the whole accumulator right.
        w_mul_sum = {1'b0, r_acc[DW-1:XLEN]}
                  + (r_a[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
        w_mul_nxt = {w_mul_sum, r_acc[XLEN-1:1]};

        // Divide: bring in the next dividend bit and subtract if it fits.
        // The partial remainder is always below the divisor, so the trial
        // value needs only one extra bit.
        w_trial   = {r_acc[XLEN-1:0], r_a[XLEN-1]};
        w_ge      = (w_trial >= {1'b0, r_b});
        w_diff    = w_trial - {1'b0, r_b};
        w_rem_nxt = w_ge ? w_diff : w_trial;
        w_quo_nxt = {r_a[XLEN-2:0], w_ge};

        // Sign fix applied to the values produced by the last iteration
        w_prod    = r_neg_res ? (-w_mul_nxt) : w_mul_nxt;
        // Divide by zero leaves the all-ones quotient un-negated
        w_quo_fix = (r_neg_res & ~r_div_zero) ? (-w_quo_nxt) : w_quo_nxt;
        w_rem_fix = r_neg_rem ? (-w_rem_nxt[XLEN-1:0]) : w_rem_nxt[XLEN-1:0];

        case (r_op)
            OP_MUL:                      w_final = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod[DW-1:XLEN];
            OP_DIV, OP_DIVU:             w_final = w_quo_fix;
            OP_REM, OP_REMU:             w_final = w_rem_fix;
            default:                     w_final = {XLEN{1'b0}};
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential control and datapath
    // ------------------------------------------------------------------
    // FSM, operand capture, per-cycle iteration and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= {CNT_W{1'b0}};
            r_op       <= 3'b000;
            r_rd       <= 5'd0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_a        <= {XLEN{1'b0}};
            r_b        <= {XLEN{1'b0}};
            r_acc      <= {DW{1'b0}};
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= {XLEN{1'b0}};
            r_rd_out   <= 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_op       <= i_op;
                        r_rd       <= i_rd_in;
                        r_neg_res  <= w_a_neg ^ w_b_neg;
                        r_neg_rem  <= w_a_neg;
                        r_div_zero <= (i_rs2_val == {XLEN{1'b0}});
                        r_a        <= w_a_mag;
                        r_b        <= w_b_mag;
                        r_acc      <= {DW{1'b0}};
                        r_cnt      <= {CNT_W{1'b0}};
                        r_busy     <= 1'b1;
`ifdef MDU_EARLY_OUT_EN
                        if (w_early) begin
                            r_result <= w_special;
                            r_rd_out <= i_rd_in;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_CALC;
                        end
`else
                        r_state    <= S_CALC;
`endif
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                S_CALC: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_op[2]) begin
                        r_a   <= w_quo_nxt;
                        r_acc <= {{(DW-XLEN-1){1'b0}}, w_rem_nxt};
                    end else begin
                        r_a   <= {1'b0, r_a[XLEN-1:1]};
                        r_acc <= w_mul_nxt;
                    end
                    if (r_cnt == CNT_W'(XLEN - 1)) begin
                        r_result <= w_final;
                        r_rd_out <= r_rd;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_state  <= S_CALC;
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = r_result;
    assign o_rd_out = r_rd_out;

endmodule
